// File: rtl/mux_arb_nch_pkg.sv
// Shared constants and helpers for the N-channel registered mux/arbiter.
package mux_arb_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Increment with wrap at n; used to advance the round-robin pointer.
    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/mux_arb_nch_if.sv
// Stream/control bundle between N upstream sources, the mux and one sink.
interface mux_arb_nch_if #(
    parameter int N = 16,
    parameter int W = 4
);
    localparam int SW = (N > 1) ? $clog2(N) : 1;

    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic           mode;
    logic [SW-1:0]  sel;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_ready;
    logic [SW-1:0]  out_sel;

    modport master (
        output in_data, in_valid, mode, sel, out_ready,
        input  in_ready, out_data, out_valid, out_sel
    );

    modport slave (
        input  in_data, in_valid, mode, sel, out_ready,
        output in_ready, out_data, out_valid, out_sel
    );
endinterface

// File: rtl/mux_arb_nch_rr_arbiter.sv
// Round-robin grant search: masked (>= ptr) priority encoder, falling back to
// the unmasked encoder when nothing at or above ptr is requesting.
module rr_arbiter #(
    parameter int N  = 16,
    parameter int SW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [SW-1:0] ptr_i,
    output logic [SW-1:0] gnt_idx_o,
    output logic          gnt_vld_o
);

    logic [N-1:0]  masked;
    logic [SW-1:0] m_idx;
    logic          m_vld;
    logic [SW-1:0] u_idx;
    logic          u_vld;

    always_comb begin
        masked = '0;
        for (int k = 0; k < N; k++) begin
            masked[k] = req_i[k] && (k >= int'(ptr_i));
        end
    end

    // Downward scan so the lowest set index wins.
    always_comb begin
        m_idx = '0;
        m_vld = 1'b0;
        u_idx = '0;
        u_vld = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (masked[k]) begin
                m_idx = SW'(k);
                m_vld = 1'b1;
            end
            if (req_i[k]) begin
                u_idx = SW'(k);
                u_vld = 1'b1;
            end
        end
    end

    assign gnt_idx_o = m_vld ? m_idx : u_idx;
    assign gnt_vld_o = u_vld;

endmodule

// File: rtl/mux_arb_nch.sv
// N-channel W-bit registered multiplexer with fixed-select and round-robin
// arbitration, valid/ready on every input and one registered output stage.
module mux_arb_nch
    import mux_arb_pkg::*;
#(
    parameter int N = 16,
    parameter int W = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    mux_arb_nch_if.slave  bus
);

    localparam int SW = (N > 1) ? $clog2(N) : 1;

    logic [W-1:0]  out_data_q, out_data_d;
    logic [SW-1:0] out_sel_q, out_sel_d;
    logic          out_valid_q, out_valid_d;
    logic [SW-1:0] ptr_q, ptr_d;

    logic          ld;
    logic          rr_mode;
    logic [SW-1:0] rr_idx;
    logic          rr_vld;
    logic [SW-1:0] fix_idx;
    logic          fix_vld;
    logic [SW-1:0] gnt_idx;
    logic          gnt_vld;
    logic          xfer;
    logic [W-1:0]  gnt_data;

    rr_arbiter #(.N(N), .SW(SW)) u_rr (
        .req_i     (bus.in_valid),
        .ptr_i     (ptr_q),
        .gnt_idx_o (rr_idx),
        .gnt_vld_o (rr_vld)
    );

    assign ld      = ~out_valid_q | bus.out_ready;
    assign rr_mode = (bus.mode == MODE_RR);

    // Out-of-range select values (non power-of-two N) never grant.
    always_comb begin
        fix_idx = bus.sel;
        fix_vld = 1'b0;
        if (int'(bus.sel) < N) begin
            fix_vld = bus.in_valid[bus.sel];
        end
    end

    assign gnt_idx = rr_mode ? rr_idx : fix_idx;
    assign gnt_vld = rr_mode ? rr_vld : fix_vld;
    assign xfer    = ld & gnt_vld;

    always_comb begin
        bus.in_ready = '0;
        for (int k = 0; k < N; k++) begin
            bus.in_ready[k] = rst_n & xfer & (gnt_idx == SW'(k));
        end
    end

    always_comb begin
        gnt_data = '0;
        for (int k = 0; k < N; k++) begin
            if (gnt_idx == SW'(k)) begin
                gnt_data = bus.in_data[k*W +: W];
            end
        end
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (ld) begin
            if (gnt_vld) begin
                out_data_d  = gnt_data;
                out_sel_d   = gnt_idx;
                out_valid_d = 1'b1;
                if (rr_mode) begin
                    ptr_d = SW'(wrap_inc(int'(gnt_idx), N));
                end
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_sel_q   <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_sel   = out_sel_q;
    assign bus.out_valid = out_valid_q;

endmodule
